// File: rtl/crab_mem_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package crab_mem_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_RESP,
    ST_WR_RESP
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } size_t;

  // Reserved size codes (011/110/111) fall through to word.
  function automatic size_t io_size(input logic [2:0] io_mode);
    case (io_mode)
      3'b000, 3'b100: io_size = SIZE_BYTE;
      3'b001, 3'b101: io_size = SIZE_HALF;
      default:        io_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One master's request/response bus into the memory arbiter.
interface mem_arbiter_if;
  logic        addr_valid;
  logic [31:0] addr;
  logic        data_valid;
  logic [31:0] data;
  logic [2:0]  io_mode;
  logic        ack;
  logic        ready;
  logic [31:0] rdata;
  logic        write_done;

  modport master (
    output addr_valid, addr, data_valid, data, io_mode, ack,
    input  ready, rdata, write_done
  );

  modport slave (
    input  addr_valid, addr, data_valid, data, io_mode, ack,
    output ready, rdata, write_done
  );
endinterface

// File: rtl/mem_strobe_gen.sv
// Byte-lane enables and lane-aligned write data for a sized store.
module mem_strobe_gen
  import crab_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  io_mode,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    wstrb      = 4'b1111;
    wdata      = data;
    misaligned = 1'b0;
    case (io_size(io_mode))
      SIZE_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = data << {addr_lo, 3'b000};
      end
      SIZE_HALF: begin
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = data << {addr_lo[1], 4'b0000};
        misaligned = addr_lo[0];
      end
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a core and a loader one-at-a-time access to a
// single-port RAM with sized writes and toggle-acknowledged read responses.
module mem_arbiter
  import crab_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave m0,
  mem_arbiter_if.slave m1,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata
);

  logic [NUM_MASTERS-1:0] req_valid, req_write, req_ack;
  logic [31:0] req_addr [NUM_MASTERS];
  logic [31:0] req_data [NUM_MASTERS];
  logic [2:0]  req_mode [NUM_MASTERS];

  assign req_valid = {m1.addr_valid, m0.addr_valid};
  assign req_write = {m1.data_valid, m0.data_valid};
  assign req_ack   = {m1.ack, m0.ack};
  assign req_addr[0] = m0.addr;
  assign req_addr[1] = m1.addr;
  assign req_data[0] = m0.data;
  assign req_data[1] = m1.data;
  assign req_mode[0] = m0.io_mode;
  assign req_mode[1] = m1.io_mode;

  state_t                 state_reg;
  logic                   grant_reg, last_grant_reg, ack_snap_reg;
  logic                   write_reg, rd_first_reg;
  logic                   ram_en_reg, ram_we_reg;
  logic [29:0]            ram_addr_reg;
  logic [31:0]            ram_wdata_reg;
  logic [3:0]             ram_wstrb_reg;
  logic [NUM_MASTERS-1:0] ready_reg, done_reg;
  logic [31:0]            rdata_reg [NUM_MASTERS];
  logic [31:0]            rdata_out [NUM_MASTERS];

  logic        next_grant;
  logic [3:0]  gen_wstrb;
  logic [31:0] gen_wdata;
  logic        gen_misaligned;

  always_comb begin
    next_grant = 1'b0;
    if (req_valid[0] && req_valid[1]) next_grant = ~last_grant_reg;
    else if (req_valid[1])            next_grant = 1'b1;
  end

  mem_strobe_gen u_strobe (
    .addr_lo    (req_addr[next_grant][1:0]),
    .io_mode    (req_mode[next_grant]),
    .data       (req_data[next_grant]),
    .wstrb      (gen_wstrb),
    .wdata      (gen_wdata),
    .misaligned (gen_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ack_snap_reg   <= 1'b0;
      write_reg      <= 1'b0;
      rd_first_reg   <= 1'b0;
      ram_en_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_wdata_reg  <= '0;
      ram_wstrb_reg  <= '0;
      ready_reg      <= '0;
      done_reg       <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) rdata_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (|req_valid) begin
          grant_reg      <= next_grant;
          last_grant_reg <= next_grant;
          ack_snap_reg   <= req_ack[next_grant];
          write_reg      <= req_write[next_grant];
          // A misaligned store completes without touching the RAM.
          ram_en_reg     <= ~(req_write[next_grant] & gen_misaligned);
          ram_we_reg     <= req_write[next_grant];
          ram_addr_reg   <= req_addr[next_grant][31:2];
          ram_wdata_reg  <= gen_wdata;
          ram_wstrb_reg  <= gen_wstrb;
          state_reg      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          ram_en_reg <= 1'b0;
          ram_we_reg <= 1'b0;
          if (write_reg) begin
            done_reg[grant_reg] <= 1'b1;
            state_reg           <= ST_WR_RESP;
          end else begin
            ready_reg[grant_reg] <= 1'b1;
            rd_first_reg         <= 1'b1;
            state_reg            <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          rd_first_reg <= 1'b0;
          if (rd_first_reg) rdata_reg[grant_reg] <= ram_rdata;
          if (req_ack[grant_reg] != ack_snap_reg) begin
            ready_reg[grant_reg] <= 1'b0;
            state_reg            <= ST_IDLE;
          end
        end
        ST_WR_RESP: if (!req_write[grant_reg]) begin
          done_reg[grant_reg] <= 1'b0;
          state_reg           <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // RAM data arrives in the first response cycle; show it directly until it is captured.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_rdata
      assign rdata_out[gi] = (rd_first_reg && grant_reg == 1'(gi)) ? ram_rdata : rdata_reg[gi];
    end
  endgenerate

  assign m0.ready      = ready_reg[0];
  assign m1.ready      = ready_reg[1];
  assign m0.write_done = done_reg[0];
  assign m1.write_done = done_reg[1];
  assign m0.rdata      = rdata_out[0];
  assign m1.rdata      = rdata_out[1];

  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign ram_wstrb = ram_wstrb_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a RAM model and a RAM-op scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_en, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [64];

  mem_arbiter_if m0_if ();
  mem_arbiter_if m1_if ();

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wstrb (ram_wstrb),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[5:0]];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } ramop_t;
  ramop_t sb [$];

  // Every RAM strobe must match the next expected operation, in order.
  always @(negedge clk) begin
    if (ram_en) begin
      if (sb.size() == 0) begin
        check("unexpected_ram_en", {2'b00, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        ramop_t e;
        e = sb.pop_front();
        check("ram_addr", {2'b00, ram_addr}, {2'b00, e.addr});
        check("ram_we", {31'd0, ram_we}, {31'd0, e.we});
        if (e.we) begin
          check("ram_wstrb", {28'd0, ram_wstrb}, {28'd0, e.strb});
          check("ram_wdata", ram_wdata, e.wdata);
        end
      end
    end
    if ((m0_if.ready | m0_if.write_done) && (m1_if.ready | m1_if.write_done))
      check("response_overlap", 32'd1, 32'd0);
  end

  function automatic logic rdy(input bit m);
    return m ? m1_if.ready : m0_if.ready;
  endfunction
  function automatic logic wd(input bit m);
    return m ? m1_if.write_done : m0_if.write_done;
  endfunction
  function automatic logic [31:0] rd(input bit m);
    return m ? m1_if.rdata : m0_if.rdata;
  endfunction

  task automatic drive(input bit m, input bit av, input logic [31:0] a, input bit dv,
                       input logic [31:0] d, input logic [2:0] md);
    if (m) begin
      m1_if.addr_valid = av; m1_if.addr = a; m1_if.data_valid = dv; m1_if.data = d; m1_if.io_mode = md;
    end else begin
      m0_if.addr_valid = av; m0_if.addr = a; m0_if.data_valid = dv; m0_if.data = d; m0_if.io_mode = md;
    end
  endtask

  task automatic toggle_ack(input bit m);
    if (m) m1_if.ack = ~m1_if.ack;
    else   m0_if.ack = ~m0_if.ack;
  endtask

  task automatic push_op(input logic [31:0] a, input bit we, input logic [3:0] s, input logic [31:0] d);
    ramop_t e;
    e.addr = a[31:2]; e.we = we; e.strb = s; e.wdata = d;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input bit m, input string name, output bit got);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      got = rdy(m);
    end
    if (!got) check(name, 32'd0, 32'd1);
  endtask

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
    bit          exp_en;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic do_txn(input int idx, input vec_t v);
    int lat;
    bit got;
    @(negedge clk);
    drive(v.m, 1'b1, v.addr, v.wr, v.data, v.mode);
    if (v.exp_en) push_op(v.addr, v.wr, v.exp_strb, v.exp_wdata);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = v.wr ? wd(v.m) : rdy(v.m);
    end
    check($sformatf("latency[%0d]", idx), lat, 2);
    if (v.wr) begin
      drive(v.m, 1'b0, v.addr, 1'b0, v.data, v.mode);
      @(negedge clk);
      check($sformatf("write_done_clear[%0d]", idx), {31'd0, wd(v.m)}, 32'd0);
    end else begin
      check($sformatf("rdata[%0d]", idx), rd(v.m), v.exp_rdata);
      drive(v.m, 1'b0, v.addr, 1'b0, v.data, v.mode);
      @(negedge clk);
      check($sformatf("ready_hold[%0d]", idx), {31'd0, rdy(v.m)}, 32'd1);
      toggle_ack(v.m);
      @(negedge clk);
      check($sformatf("ready_clear[%0d]", idx), {31'd0, rdy(v.m)}, 32'd0);
    end
    $display("txn %0d: m%0d %s addr=%h data=%h mode=%b rdata=%h", idx, v.m,
             v.wr ? "WR" : "RD", v.addr, v.data, v.mode, rd(v.m));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int q0, q1, order [$];

    for (int i = 0; i < 64; i++) mem[i] = 32'h1111_0000 | i;
    mem[2] = 32'hDEAD_BEEF;

    vecs[0]  = '{0, 0, 32'h08, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{0, 1, 32'h13, 32'h0000_00AB, 3'b000, 1, 4'b1000, 32'hAB00_0000, 32'h0};
    vecs[2]  = '{0, 0, 32'h10, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'hAB11_0004};
    vecs[3]  = '{1, 1, 32'h22, 32'h0000_BEEF, 3'b001, 1, 4'b1100, 32'hBEEF_0000, 32'h0};
    vecs[4]  = '{1, 0, 32'h20, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'hBEEF_0008};
    vecs[5]  = '{1, 1, 32'h06, 32'h1234_5678, 3'b010, 0, 4'h0,    32'h0,        32'h0};
    vecs[6]  = '{1, 0, 32'h04, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'h1111_0001};
    vecs[7]  = '{0, 1, 32'h31, 32'h0000_5555, 3'b101, 0, 4'h0,    32'h0,        32'h0};
    vecs[8]  = '{0, 0, 32'h30, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'h1111_000C};
    vecs[9]  = '{0, 1, 32'h14, 32'hCAFE_F00D, 3'b111, 1, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1, 0, 32'h14, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'hCAFE_F00D};
    vecs[11] = '{0, 1, 32'h15, 32'h0000_00EE, 3'b100, 1, 4'b0010, 32'h0000_EE00, 32'h0};
    vecs[12] = '{0, 0, 32'h14, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'hCAFE_EE0D};
    vecs[13] = '{1, 1, 32'h1C, 32'h0BAD_CAFE, 3'b011, 1, 4'b1111, 32'h0BAD_CAFE, 32'h0};
    vecs[14] = '{1, 0, 32'h1C, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'h0BAD_CAFE};
    vecs[15] = '{0, 1, 32'h02, 32'h0000_1234, 3'b001, 1, 4'b1100, 32'h1234_0000, 32'h0};
    vecs[16] = '{0, 0, 32'h00, 32'h0,        3'b010, 1, 4'h0,    32'h0,        32'h1234_0000};

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
    m0_if.ack = 1'b0;
    m1_if.ack = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_m0_ready", {31'd0, m0_if.ready}, 32'd0);
    check("rst_m1_done", {31'd0, m1_if.write_done}, 32'd0);
    check("rst_m0_rdata", m0_if.rdata, 32'd0);
    check("rst_m1_rdata", m1_if.rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) do_txn(i, vecs[i]);

    // addr_valid dropped while in ACCESS must not abort the read
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h08, 1'b0, 32'h0, 3'b010);
    push_op(32'h08, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h08, 1'b0, 32'h0, 3'b010);
    wait_ready(1'b0, "drop_valid_ready", got);
    check("drop_valid_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      check("drop_valid_hold", {31'd0, m0_if.ready}, 32'd1);
    end
    toggle_ack(1'b0);
    @(negedge clk);
    check("drop_valid_clear", {31'd0, m0_if.ready}, 32'd0);
    $display("txn drop_valid: m0 RD addr=00000008 rdata=%h", m0_if.rdata);

    // Reset while a read response is held
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 3'b010);
    push_op(32'h10, 1'b0, 4'h0, 32'h0);
    wait_ready(1'b0, "rst_mid_ready", got);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
    @(negedge clk);
    check("rst_mid_ready_low", {31'd0, m0_if.ready}, 32'd0);
    check("rst_mid_rdata_zero", m0_if.rdata, 32'd0);
    check("rst_mid_ram_en", {31'd0, ram_en}, 32'd0);
    reset = 1'b0;
    $display("txn reset_mid: m0 RD discarded by reset");
    do_txn(100, vecs[0]);

    // m0 ack withheld: m1 must wait with its request pending
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 3'b010);
    push_op(32'h14, 1'b0, 4'h0, 32'h0);
    wait_ready(1'b0, "hold_m0_ready", got);
    check("hold_m0_rdata", m0_if.rdata, 32'hCAFE_EE0D);
    drive(1'b0, 1'b0, 32'h14, 1'b0, 32'h0, 3'b010);
    drive(1'b1, 1'b1, 32'h1C, 1'b0, 32'h0, 3'b010);
    push_op(32'h1C, 1'b0, 4'h0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_m0_ready_high", {31'd0, m0_if.ready}, 32'd1);
      check("hold_m1_ready_low", {31'd0, m1_if.ready}, 32'd0);
    end
    toggle_ack(1'b0);
    wait_ready(1'b1, "hold_m1_ready", got);
    check("hold_m1_rdata", m1_if.rdata, 32'h0BAD_CAFE);
    check("hold_m0_released", {31'd0, m0_if.ready}, 32'd0);
    drive(1'b1, 1'b0, 32'h1C, 1'b0, 32'h0, 3'b010);
    toggle_ack(1'b1);
    @(negedge clk);
    check("hold_m1_clear", {31'd0, m1_if.ready}, 32'd0);
    $display("txn ack_hold: m0 held 10 cycles, then m1 rdata=%h", m1_if.rdata);

    // Simultaneous requests three times back-to-back after reset
    pulse_reset();
    q0 = 2;
    q1 = 1;
    push_op(32'h08, 1'b0, 4'h0, 32'h0);
    push_op(32'h10, 1'b0, 4'h0, 32'h0);
    push_op(32'h08, 1'b0, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 32'h08, 1'b0, 32'h0, 3'b010);
    drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 3'b010);
    for (int c = 0; c < 40 && (q0 > 0 || q1 > 0); c++) begin
      @(negedge clk);
      if (m0_if.ready) begin
        order.push_back(0);
        check("rr_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        toggle_ack(1'b0);
        q0--;
        if (q0 == 0) drive(1'b0, 1'b0, 32'h08, 1'b0, 32'h0, 3'b010);
      end
      if (m1_if.ready) begin
        order.push_back(1);
        check("rr_m1_rdata", m1_if.rdata, 32'hAB11_0004);
        toggle_ack(1'b1);
        q1--;
        if (q1 == 0) drive(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 3'b010);
      end
    end
    @(negedge clk);
    check("rr_count", order.size(), 3);
    if (order.size() == 3) begin
      check("rr_grant0", order[0], 0);
      check("rr_grant1", order[1], 1);
      check("rr_grant2", order[2], 0);
    end
    $display("txn round_robin: %0d grants completed", order.size());

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
